// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 32;

    // Reset PC and bubble encoding (addi x0,x0,0)
    localparam logic [PC_W-1:0]   RESET_PC = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StHold,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bundle: hazard controls, instruction-memory handshake and IF/ID outputs.
interface fetch_if;
    import fetch_pkg::*;

    logic              stall;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic [PC_W-1:0]   if_id_pc;
    logic [INST_W-1:0] if_id_inst;
    logic              if_id_valid;

    // Fetch stage side
    modport master (
        input  stall, redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, if_id_pc, if_id_inst, if_id_valid
    );

    // Pipeline / memory environment side
    modport slave (
        output stall, redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, if_id_pc, if_id_inst, if_id_valid
    );

endinterface

// File: rtl/fetch_perf_ctr.sv
// Three saturating 32-bit event counters for the fetch stage.
module fetch_perf_ctr (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_stall,
    input  logic        inc_flush,
    input  logic        inc_wait,
    output logic [31:0] stall_cycles,
    output logic [31:0] flushes,
    output logic [31:0] imem_wait
);

    // Count each event, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flushes      <= '0;
            imem_wait    <= '0;
        end else begin
            if (inc_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
            if (inc_flush && (flushes != '1))      flushes      <= flushes + 32'd1;
            if (inc_wait && (imem_wait != '1))     imem_wait    <= imem_wait + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem requests, skid
// buffer for responses arriving under stall, and the IF/ID pipeline register.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter logic [fetch_pkg::PC_W-1:0]   RESET_PC = fetch_pkg::RESET_PC,
    parameter logic [fetch_pkg::INST_W-1:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_imem_wait
`endif
);
    import fetch_pkg::*;

    fetch_state_e      state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   req_pc;
    logic [PC_W-1:0]   skid_pc;
    logic [INST_W-1:0] skid_inst;
    logic [PC_W-1:0]   if_id_pc;
    logic [INST_W-1:0] if_id_inst;
    logic              if_id_valid;

    // Request outputs decode registered state only; reset masks a stale request
    always_comb begin
        bus.imem_req    = (state == StFetch) && !rst;
        bus.imem_addr   = pc;
        bus.if_id_pc    = if_id_pc;
        bus.if_id_inst  = if_id_inst;
        bus.if_id_valid = if_id_valid;
    end

    // Fetch FSM, PC, skid buffer and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StFetch;
            pc          <= RESET_PC;
            req_pc      <= '0;
            skid_pc     <= '0;
            skid_inst   <= NOP_INST;
            if_id_pc    <= '0;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else if (bus.redirect) begin
            pc          <= bus.redirect_pc & ~32'd3;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
            skid_inst   <= NOP_INST;
            // A response is still owed if a request remains in flight after this edge
            unique case (state)
                StFetch: state <= bus.imem_ready ? StDrain : StFetch;
                StWait:  state <= bus.imem_rvalid ? StFetch : StDrain;
                StHold:  state <= StFetch;
                StDrain: state <= bus.imem_rvalid ? StFetch : StDrain;
                default: state <= StFetch;
            endcase
        end else begin
            // Default IF/ID behaviour: hold under stall, otherwise insert a bubble
            if (!bus.stall) begin
                if_id_inst  <= NOP_INST;
                if_id_valid <= 1'b0;
            end
            unique case (state)
                StFetch: begin
                    if (bus.imem_ready) begin
                        req_pc <= pc;
                        state  <= StWait;
                    end
                end
                StWait: begin
                    if (bus.imem_rvalid) begin
                        pc <= req_pc + 32'd4;
                        if (bus.stall) begin
                            skid_pc   <= req_pc;
                            skid_inst <= bus.imem_rdata;
                            state     <= StHold;
                        end else begin
                            if_id_pc    <= req_pc;
                            if_id_inst  <= bus.imem_rdata;
                            if_id_valid <= 1'b1;
                            state       <= StFetch;
                        end
                    end
                end
                StHold: begin
                    if (!bus.stall) begin
                        if_id_pc    <= skid_pc;
                        if_id_inst  <= skid_inst;
                        if_id_valid <= 1'b1;
                        state       <= StFetch;
                    end
                end
                StDrain: begin
                    if (bus.imem_rvalid) state <= StFetch;
                end
                default: state <= StFetch;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    fetch_perf_ctr u_perf (
        .clk          (clk),
        .rst          (rst),
        .inc_stall    (bus.stall && if_id_valid),
        .inc_flush    (bus.redirect),
        .inc_wait     ((state == StWait) && !bus.imem_rvalid),
        .stall_cycles (perf_stall_cycles),
        .flushes      (perf_flushes),
        .imem_wait    (perf_imem_wait)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory handshake is driven cycle by cycle.
module tb_fetch_stage;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    fetch_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushes;
    logic [31:0] perf_imem_wait;
`endif

    fetch_stage dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus.master)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes),
        .perf_imem_wait    (perf_imem_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] epc, input logic [31:0] einst,
                            input logic evalid);
        chk({tag, "_pc"}, bus.if_id_pc, epc);
        chk({tag, "_inst"}, bus.if_id_inst, einst);
        chk({tag, "_valid"}, {31'd0, bus.if_id_valid}, {31'd0, evalid});
    endtask

    initial begin
        n_assert        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        step();
        step();
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk_ifid("rst", 32'h0, 32'h0000_0013, 1'b0);

        // Zero-wait fetch from 0x0
        rst = 1'b0;
        bus.imem_ready = 1'b1;
        #1;
        chk("f0_req", {31'd0, bus.imem_req}, 32'd1);
        chk("f0_addr", bus.imem_addr, 32'h0);
        step();
        bus.imem_ready = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h0000_0093;
        chk("w0_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        chk_ifid("i0", 32'h0, 32'h0000_0093, 1'b1);
        chk("f1_addr", bus.imem_addr, 32'h4);
        chk("f1_req", {31'd0, bus.imem_req}, 32'd1);

        // Fetch 0x4; IF/ID bubbles while the request is in flight
        bus.imem_rvalid = 1'b0;
        bus.imem_ready = 1'b1;
        step();
        chk_ifid("bub1", 32'h0, 32'h0000_0013, 1'b0);
        bus.imem_ready = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h0000_0113;
        step();
        chk_ifid("i1", 32'h4, 32'h0000_0113, 1'b1);
        chk("f2_addr", bus.imem_addr, 32'h8);

        // Stall three cycles while the 0x8 response arrives
        bus.imem_rvalid = 1'b0;
        bus.imem_ready = 1'b1;
        bus.stall = 1'b1;
        step();
        chk_ifid("st1", 32'h4, 32'h0000_0113, 1'b1);
        bus.imem_ready = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h0020_8193;
        step();
        chk_ifid("st2", 32'h4, 32'h0000_0113, 1'b1);
        chk("st2_req", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b0;
        step();
        chk_ifid("st3", 32'h4, 32'h0000_0113, 1'b1);
        chk("st3_req", {31'd0, bus.imem_req}, 32'd0);
        bus.stall = 1'b0;
        step();
        chk_ifid("skid", 32'h8, 32'h0020_8193, 1'b1);
        chk("skid_addr", bus.imem_addr, 32'hC);
        chk("skid_req", {31'd0, bus.imem_req}, 32'd1);

        // Redirect while waiting on 0xC; its response must be dropped
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        step();
        chk_ifid("rd", 32'h8, 32'h0000_0013, 1'b0);
        chk("rd_req", {31'd0, bus.imem_req}, 32'd0);
        bus.redirect = 1'b0;
        step();
        chk("drain_req", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        chk_ifid("drop", 32'h8, 32'h0000_0013, 1'b0);
        chk("rd_addr", bus.imem_addr, 32'h100);
        chk("rd_freq", {31'd0, bus.imem_req}, 32'd1);

        // Load 0x100, then redirect and stall together
        bus.imem_rvalid = 1'b0;
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h0000_0213;
        step();
        chk_ifid("i100", 32'h100, 32'h0000_0213, 1'b1);
        bus.imem_rvalid = 1'b0;
        bus.redirect = 1'b1;
        bus.stall = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        chk_ifid("rdst", 32'h100, 32'h0000_0013, 1'b0);
        chk("rdst_addr", bus.imem_addr, 32'hFFFF_FFFC);

        // Memory not ready for five cycles: address must stay put
        bus.redirect = 1'b0;
        bus.stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("nr_addr", bus.imem_addr, 32'hFFFF_FFFC);
            chk("nr_req", {31'd0, bus.imem_req}, 32'd1);
        end
        bus.imem_ready = 1'b1;
        step();
        chk("acc_req", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_ready = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'h0000_0313;
        step();
        chk_ifid("wrap", 32'hFFFF_FFFC, 32'h0000_0313, 1'b1);
        chk("wrap_addr", bus.imem_addr, 32'h0);

`ifdef FETCH_PERF_EN
        chk("perf_stall", perf_stall_cycles, 32'd4);
        chk("perf_flush", perf_flushes, 32'd2);
        chk("perf_wait", perf_imem_wait, 32'd1);
`endif

        // Reset in the middle of a transaction
        bus.imem_rvalid = 1'b0;
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk_ifid("mrst", 32'h0, 32'h0000_0013, 1'b0);
        chk("mrst_addr", bus.imem_addr, 32'h0);
        chk("mrst_freq", {31'd0, bus.imem_req}, 32'd1);
`ifdef FETCH_PERF_EN
        chk("perf_rst", perf_flushes, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
